// File: rtl/bulk_axi_pkg.sv
// Shared types and AXI encodings for the bulk line-to-AXI bridge.
package bulk_axi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrXfer,
    StWrResp,
    StResp
  } state_e;

  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  function automatic logic [2:0] axsize(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/bulk_line_buffer.sv
// One cache line of data and strobes: parallel load, beat-indexed write and read.
module bulk_line_buffer #(
  parameter int unsigned LINE_BEATS = 16,
  parameter int unsigned DATA_W     = 64,
  localparam int unsigned IdxW      = $clog2(LINE_BEATS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_i,
  input  logic [LINE_BEATS*DATA_W-1:0]   load_data_i,
  input  logic [LINE_BEATS*DATA_W/8-1:0] load_strb_i,
  input  logic                           wr_en_i,
  input  logic [IdxW-1:0]                idx_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  output logic [DATA_W-1:0]              rd_data_o,
  output logic [DATA_W/8-1:0]            rd_strb_o,
  output logic [LINE_BEATS*DATA_W-1:0]   line_o
);

  localparam int unsigned StrbW = DATA_W / 8;

  logic [LINE_BEATS*DATA_W-1:0] data_q, data_d;
  logic [LINE_BEATS*StrbW-1:0]  strb_q, strb_d;

  always_comb begin
    data_d = data_q;
    strb_d = strb_q;
    if (load_i) begin
      data_d = load_data_i;
      strb_d = load_strb_i;
    end else if (wr_en_i) begin
      data_d[idx_i*DATA_W +: DATA_W] = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      strb_q <= '0;
    end else begin
      data_q <= data_d;
      strb_q <= strb_d;
    end
  end

  assign rd_data_o = data_q[idx_i*DATA_W +: DATA_W];
  assign rd_strb_o = strb_q[idx_i*StrbW +: StrbW];
  assign line_o    = data_q;

endmodule

// File: rtl/bulk_line_axi_bridge.sv
// Moves whole lines between a simple request/response port and AXI4 INCR bursts.
module bulk_line_axi_bridge
  import bulk_axi_pkg::*;
#(
  parameter int unsigned LINE_BEATS = 16,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned AXI_ID     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [LINE_BEATS*DATA_W-1:0]   req_wdata,
  input  logic [LINE_BEATS*DATA_W/8-1:0] req_wstrb,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [LINE_BEATS*DATA_W-1:0]   resp_rdata,
  output logic                           resp_err,
  output logic                           axi_arvalid,
  input  logic                           axi_arready,
  output logic [ADDR_W-1:0]              axi_araddr,
  output logic [7:0]                     axi_arlen,
  output logic [2:0]                     axi_arsize,
  output logic [1:0]                     axi_arburst,
  output logic [ID_W-1:0]                axi_arid,
  output logic [3:0]                     axi_arcache,
  output logic [2:0]                     axi_arprot,
  input  logic                           axi_rvalid,
  output logic                           axi_rready,
  input  logic [DATA_W-1:0]              axi_rdata,
  input  logic [1:0]                     axi_rresp,
  input  logic                           axi_rlast,
  output logic                           axi_awvalid,
  input  logic                           axi_awready,
  output logic [ADDR_W-1:0]              axi_awaddr,
  output logic [7:0]                     axi_awlen,
  output logic [2:0]                     axi_awsize,
  output logic [1:0]                     axi_awburst,
  output logic [ID_W-1:0]                axi_awid,
  output logic [3:0]                     axi_awcache,
  output logic [2:0]                     axi_awprot,
  output logic                           axi_wvalid,
  input  logic                           axi_wready,
  output logic [DATA_W-1:0]              axi_wdata,
  output logic [DATA_W/8-1:0]            axi_wstrb,
  output logic                           axi_wlast,
  input  logic                           axi_bvalid,
  output logic                           axi_bready,
  input  logic [1:0]                     axi_bresp,
  input  logic [ID_W-1:0]                axi_bid
);

  localparam int unsigned IdxW                = $clog2(LINE_BEATS);
  localparam int unsigned LineBytes           = LINE_BEATS * DATA_W / 8;
  localparam logic [ADDR_W-1:0] AlignMask     = ~(ADDR_W'(LineBytes - 1));
  localparam logic [IdxW-1:0]   LastBeat      = IdxW'(LINE_BEATS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IdxW-1:0]   beat_q, beat_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              req_ready_q, req_ready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              buf_load, buf_wr;
  logic              unused_resp_lsb;

  assign unused_resp_lsb = ^{axi_rresp[0], axi_bresp[0]};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    buf_load  = 1'b0;
    buf_wr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          addr_d    = req_addr & AlignMask;
          beat_d    = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          buf_load  = 1'b1;
          state_d   = req_write ? StWrXfer : StRdAddr;
        end
      end
      StRdAddr: if (axi_arready) state_d = StRdData;
      StRdData: begin
        if (axi_rvalid) begin
          buf_wr = 1'b1;
          err_d  = err_q | axi_rresp[1];
          if (axi_rlast) begin
            err_d   = err_q | axi_rresp[1] | (beat_q != LastBeat);
            state_d = StResp;
          end else if (beat_q == LastBeat) begin
            // Overlong burst: keep overwriting the last slot rather than wrapping.
            err_d = 1'b1;
          end else begin
            beat_d = beat_q + IdxW'(1);
          end
        end
      end
      StWrXfer: begin
        if (awvalid_q && axi_awready) aw_done_d = 1'b1;
        if (wvalid_q && axi_wready) begin
          if (beat_q == LastBeat) w_done_d = 1'b1;
          else                    beat_d = beat_q + IdxW'(1);
        end
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (axi_bvalid) begin
          err_d   = err_q | axi_bresp[1] | (axi_bid != ID_W'(AXI_ID));
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Handshake outputs are registered copies of the next state.
    req_ready_d  = (state_d == StIdle);
    arvalid_d    = (state_d == StRdAddr);
    rready_d     = (state_d == StRdData);
    awvalid_d    = (state_d == StWrXfer) && !aw_done_d;
    wvalid_d     = (state_d == StWrXfer) && !w_done_d;
    bready_d     = (state_d == StWrResp);
    resp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  bulk_line_buffer #(
    .LINE_BEATS(LINE_BEATS),
    .DATA_W    (DATA_W)
  ) u_line_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (buf_load),
    .load_data_i(req_wdata),
    .load_strb_i(req_wstrb),
    .wr_en_i    (buf_wr),
    .idx_i      (beat_q),
    .wr_data_i  (axi_rdata),
    .rd_data_o  (axi_wdata),
    .rd_strb_o  (axi_wstrb),
    .line_o     (resp_rdata)
  );

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = err_q;

  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = 8'(LINE_BEATS - 1);
  assign axi_arsize  = axsize(DATA_W);
  assign axi_arburst = BurstIncr;
  assign axi_arid    = ID_W'(AXI_ID);
  assign axi_arcache = 4'b0;
  assign axi_arprot  = 3'b0;
  assign axi_rready  = rready_q;

  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'(LINE_BEATS - 1);
  assign axi_awsize  = axsize(DATA_W);
  assign axi_awburst = BurstIncr;
  assign axi_awid    = ID_W'(AXI_ID);
  assign axi_awcache = 4'b0;
  assign axi_awprot  = 3'b0;
  assign axi_wvalid  = wvalid_q;
  assign axi_wlast   = wvalid_q && (beat_q == LastBeat);
  assign axi_bready  = bready_q;

endmodule
